vga_upscale_feeder: RTL and testbench

- Sits directly downstream of the VGA timing generator; consumes its registered de/line/sx/sy/HS/VS outputs.
- Pulls a 320x240 RGB source frame from an upstream pixel stream (valid/ready, start-of-frame flag).
- Drives a 2x nearest-neighbour upscaled 640x480 picture onto the DAC pins.
- Holds one source line in an internal line buffer so every source line is shown on two consecutive output lines.

---
 rtl/vga_upscale_feeder.sv | 172 +++++++++++++++++
 tb/tb_vga_upscale_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_upscale_feeder.sv
// vga_upscale_feeder: pulls a SRC_W x SRC_H pixel stream and shows it
// 2x nearest-neighbour upscaled behind the VGA timing generator.
module vga_upscale_feeder #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int DW    = 24
) (
  input  logic                clk_25M,
  input  logic                rst,
  input  logic                i_de,
  input  logic                i_line,
  input  logic signed [15:0]  i_sx,
  input  logic signed [15:0]  i_sy,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_pix_valid,
  input  logic [DW-1:0]       i_pix_data,
  input  logic                i_pix_sof,
  output logic                o_pix_ready,
  output logic [7:0]          o_vga_r,
  output logic [7:0]          o_vga_g,
  output logic [7:0]          o_vga_b,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic                o_underflow,
  output logic                o_resync,
  output logic [15:0]         o_underflow_cnt
);

  localparam logic signed [15:0] OW = 16'(2 * SRC_W);
  localparam logic signed [15:0] OH = 16'(2 * SRC_H);
  localparam int AW = $clog2(SRC_W);

  typedef enum logic [1:0] {
    S_SYNC,
    S_ARMED,
    S_ACTIVE
  } state_t;

  state_t state;

  logic          act;
  logic          origin;
  logic          start;
  logic          slot;
  logic          sof_ok;
  logic          take;
  logic          under;
  logic          resync;
  logic          show;
  logic [DW-1:0] fetch_px;
  logic [AW-1:0] addr;

  logic [DW-1:0] mem [SRC_W];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] hold;
  logic [DW-1:0] p1;
  logic          sel1;
  logic          en1;
  logic [DW-1:0] px2;
  logic          de1;
  logic          hs1;
  logic          vs1;

  // Line-start pulses carry no alignment information; the SOF flag rules.
  logic unused_ok;
  assign unused_ok = i_line;

  assign act = i_de
            && i_sx >= 16'sd0 && i_sx < OW
            && i_sy >= 16'sd0 && i_sy < OH;
  assign origin = (i_sx == 16'sd0) && (i_sy == 16'sd0);
  assign start  = (state == S_ARMED) && act && origin;
  assign slot   = start
               || ((state == S_ACTIVE) && act
                   && !i_sx[0] && !i_sy[0]);
  assign sof_ok = (i_pix_sof == origin);
  assign take   = slot && i_pix_valid && sof_ok;
  assign under  = slot && !i_pix_valid;
  assign resync = slot && i_pix_valid && !sof_ok;
  assign show   = act && (start || state == S_ACTIVE) && !resync;
  assign fetch_px = take ? i_pix_data : '0;
  assign addr   = i_sx[AW:1];

  // Mismatched beats are left at the head so S_SYNC can find the SOF.
  always_comb begin
    o_pix_ready = 1'b0;
    unique case (state)
      S_SYNC:   o_pix_ready = !(i_pix_valid && i_pix_sof);
      S_ARMED,
      S_ACTIVE: o_pix_ready = slot && sof_ok;
      default:  o_pix_ready = 1'b0;
    endcase
  end

  // Frame alignment FSM with sticky error flags and underflow counter.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state           <= S_SYNC;
      o_underflow     <= 1'b0;
      o_resync        <= 1'b0;
      o_underflow_cnt <= '0;
    end else begin
      unique case (state)
        S_SYNC:
          if (i_pix_valid && i_pix_sof) state <= S_ARMED;
        S_ARMED:
          if (start) state <= resync ? S_SYNC : S_ACTIVE;
        S_ACTIVE:
          if (resync) state <= S_SYNC;
        default:
          state <= S_SYNC;
      endcase
      if (under) begin
        o_underflow <= 1'b1;
        if (o_underflow_cnt != 16'hFFFF)
          o_underflow_cnt <= o_underflow_cnt + 16'd1;
      end
      if (resync) o_resync <= 1'b1;
    end
  end

  // Stage 1: even lines replicate the fetched pixel horizontally.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      hold <= '0;
      p1   <= '0;
      sel1 <= 1'b0;
      en1  <= 1'b0;
    end else begin
      if (slot) hold <= fetch_px;
      p1   <= slot ? fetch_px : hold;
      sel1 <= i_sy[0];
      en1  <= show;
    end
  end

  // Line buffer: written on even lines, read back on odd lines.
  always_ff @(posedge clk_25M) begin
    if (slot && !resync) mem[addr] <= fetch_px;
    rd_q <= mem[addr];
  end

  assign px2 = !en1 ? '0 : (sel1 ? rd_q : p1);

  // Stage 2: output register, syncs delayed to stay aligned.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      o_vga_r <= '0;
      o_vga_g <= '0;
      o_vga_b <= '0;
      de1     <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      o_de    <= 1'b0;
      o_hs    <= 1'b1;
      o_vs    <= 1'b1;
    end else begin
      o_vga_r <= px2[DW-1 -: 8];
      o_vga_g <= px2[DW-9 -: 8];
      o_vga_b <= px2[DW-17 -: 8];
      de1     <= i_de;
      hs1     <= i_hs;
      vs1     <= i_vs;
      o_de    <= de1;
      o_hs    <= hs1;
      o_vs    <= vs1;
    end
  end

endmodule

// File: tb/tb_vga_upscale_feeder.sv
// tb_vga_upscale_feeder: scoreboard bench on a reduced 64x32 source
// so several full frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_upscale_feeder;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int OW = 2 * W;
  localparam int OH = 2 * H;
  localparam int N  = W * H;
  localparam int SU = 10 * W + 50;
  localparam int SE = 20 * W + 60;

  logic        clk_25M = 1'b0;
  logic        rst;
  logic        i_de;
  logic        i_line;
  logic [15:0] i_sx;
  logic [15:0] i_sy;
  logic        i_hs;
  logic        i_vs;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        i_pix_sof;
  logic        o_pix_ready;
  logic [7:0]  o_vga_r;
  logic [7:0]  o_vga_g;
  logic [7:0]  o_vga_b;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic        o_underflow;
  logic        o_resync;
  logic [15:0] o_underflow_cnt;

  vga_upscale_feeder #(.SRC_W(W), .SRC_H(H), .DW(24)) dut (
    .clk_25M(clk_25M),
    .rst(rst),
    .i_de(i_de),
    .i_line(i_line),
    .i_sx(i_sx),
    .i_sy(i_sy),
    .i_hs(i_hs),
    .i_vs(i_vs),
    .i_pix_valid(i_pix_valid),
    .i_pix_data(i_pix_data),
    .i_pix_sof(i_pix_sof),
    .o_pix_ready(o_pix_ready),
    .o_vga_r(o_vga_r),
    .o_vga_g(o_vga_g),
    .o_vga_b(o_vga_b),
    .o_hs(o_hs),
    .o_vs(o_vs),
    .o_de(o_de),
    .o_underflow(o_underflow),
    .o_resync(o_resync),
    .o_underflow_cnt(o_underflow_cnt)
  );

  always #5 clk_25M = ~clk_25M;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
  } beat_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  beat_t src_q[$];
  exp_t  sb[$];
  int    n_chk;
  int    n_pass;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] dpat(input int k);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'(k % W);
    y = 8'(k / W);
    return {y, x, 8'h00};
  endfunction

  function automatic logic [23:0] exp_px(input int f, input int x,
                                         input int y, input bit post);
    int s;
    int r;
    s = (y >> 1) * W + (x >> 1);
    r = y * OW + x;
    case (f)
      0: return ((y >> 1) == 5) ? 24'hA5A5A5 : dpat(s);
      1: begin
        if (s == SU) return 24'h0;
        return (s < SU) ? dpat(s) : dpat(s - 1);
      end
      2: return (r >= 40 * OW + 120) ? 24'h0 : dpat(s);
      3: return dpat(s);
      default: return post ? 24'h0 : dpat(s);
    endcase
  endfunction

  task automatic chk_rst_state(input string tag);
    chk({tag, "_rgb"}, {8'h0, o_vga_r, o_vga_g, o_vga_b}, 32'h0);
    chk({tag, "_sync"}, {29'h0, o_hs, o_vs, o_de}, 32'h6);
    chk({tag, "_flags"}, {30'h0, o_underflow, o_resync}, 32'h0);
    chk({tag, "_cnt"}, {16'h0, o_underflow_cnt}, 32'h0);
  endtask

  initial begin
    int    sx;
    int    sy;
    int    f;
    bit    fired;
    bit    post;
    bit    did_rst;
    bit    want_sync;
    bit    seen_origin;
    int    rst_cnt;
    int    garbage;
    int    rdy10;
    int    rdy11;
    bit    act;
    bit    de;
    bit    hs;
    bit    vs;
    exp_t  e;
    beat_t b;

    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    i_de = 1'b0;
    i_line = 1'b0;
    i_sx = '0;
    i_sy = '0;
    i_hs = 1'b1;
    i_vs = 1'b1;
    i_pix_valid = 1'b0;
    i_pix_data = '0;
    i_pix_sof = 1'b0;

    for (int i = 0; i < 50; i++) begin
      b.d = 24'($urandom);
      b.sof = 1'b0;
      src_q.push_back(b);
    end
    for (int k = 0; k < N; k++) begin
      b.d = ((k / W) == 5) ? 24'hA5A5A5 : dpat(k);
      b.sof = (k == 0);
      src_q.push_back(b);
    end
    for (int k = 0; k < N - 1; k++) begin
      b.d = dpat(k);
      b.sof = (k == 0);
      src_q.push_back(b);
    end
    for (int k = 0; k < SE; k++) begin
      b.d = dpat(k);
      b.sof = (k == 0);
      src_q.push_back(b);
    end
    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < N; k++) begin
        b.d = dpat(k);
        b.sof = (k == 0);
        src_q.push_back(b);
      end
    end

    repeat (3) @(posedge clk_25M);
    #1;
    chk_rst_state("reset");
    rst = 1'b0;

    sx = -2;
    sy = -2;
    f = 0;
    fired = 1'b0;
    post = 1'b0;
    did_rst = 1'b0;
    want_sync = 1'b0;
    seen_origin = 1'b0;
    rst_cnt = 0;
    garbage = 0;
    rdy10 = 0;
    rdy11 = 0;

    while (f < 5) begin
      @(posedge clk_25M);
      #1;
      if (fired) void'(src_q.pop_front());
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        chk($sformatf("pix f%0d (%0d,%0d)", f, sx, sy),
            {5'h0, o_vga_r, o_vga_g, o_vga_b, o_de, o_hs, o_vs},
            {5'h0, e});
      end

      if (sx == -2 && sy == -2 && f >= 1) begin
        case (f - 1)
          0: begin
            chk("f0_flags", {30'h0, o_underflow, o_resync}, 32'h0);
            chk("f0_cnt", {16'h0, o_underflow_cnt}, 32'h0);
            chk("f0_ready_l10", 32'(rdy10), 32'(W));
            chk("f0_ready_l11", 32'(rdy11), 32'h0);
          end
          1: begin
            chk("f1_flags", {30'h0, o_underflow, o_resync}, 32'h2);
            chk("f1_cnt", {16'h0, o_underflow_cnt}, 32'h1);
          end
          2, 3: begin
            chk("f23_flags", {30'h0, o_underflow, o_resync}, 32'h3);
            chk("f23_cnt", {16'h0, o_underflow_cnt}, 32'h1);
          end
          default: begin
            chk("f4_flags", {30'h0, o_underflow, o_resync}, 32'h0);
            chk("f4_cnt", {16'h0, o_underflow_cnt}, 32'h0);
          end
        endcase
      end
      if (f == 0 && sx == 0 && sy == 0)
        chk("garbage_dropped", 32'(garbage), 32'd50);

      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) begin
          rst = 1'b0;
          want_sync = 1'b1;
        end
      end
      if (f == 4 && sx == 101 && sy == 50 && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        chk_rst_state("async_rst");
        sb.delete();
        post = 1'b1;
        rst_cnt = 3;
      end

      act = (sx >= 0 && sx < OW && sy >= 0 && sy < OH);
      de = (sx >= -1 && sx <= OW) && (sy >= 0 && sy < OH);
      hs = !(sx >= OW);
      vs = (sy != -2);
      i_sx = 16'(sx);
      i_sy = 16'(sy);
      i_de = de;
      i_hs = hs;
      i_vs = vs;
      i_line = (sx == -2);
      i_pix_valid = !rst && (src_q.size() > 0)
                 && !(f == 1 && sx == 100 && sy == 20);
      if (src_q.size() > 0) begin
        i_pix_data = src_q[0].d;
        i_pix_sof = src_q[0].sof;
      end else begin
        i_pix_data = '0;
        i_pix_sof = 1'b0;
      end
      if (!rst) begin
        e.rgb = act ? exp_px(f, sx, sy, post) : 24'h0;
        e.de = de;
        e.hs = hs;
        e.vs = vs;
        sb.push_back(e);
      end

      #3;
      fired = i_pix_valid && o_pix_ready;
      if (f == 0 && sx == 0 && sy == 0) seen_origin = 1'b1;
      if (fired && !i_pix_sof && f == 0 && !seen_origin) garbage++;
      if (f == 0 && sy == 10 && o_pix_ready) rdy10++;
      if (f == 0 && sy == 11 && o_pix_ready) rdy11++;
      if (want_sync && !rst && sx[0]) begin
        chk("sync_ready_after_rst", {31'h0, o_pix_ready}, 32'h1);
        want_sync = 1'b0;
      end

      sx++;
      if (sx > OW + 1) begin
        sx = -2;
        sy++;
        if (sy > OH - 1) begin
          sy = -2;
          f++;
        end
      end
    end

    @(posedge clk_25M);
    #1;
    chk("final_flags", {30'h0, o_underflow, o_resync}, 32'h0);
    chk("final_cnt", {16'h0, o_underflow_cnt}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
